// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP framing parser: K-codes, FSM states and length limits.
package tlp_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam int LEN_W_DEF   = 13;
  localparam int MIN_LEN_DEF = 18;
  localparam int MAX_LEN_DEF = 4122;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TLP  = 2'd1,
    ST_DLLP = 2'd2
  } tlpState_e;

endpackage

// File: rtl/sat_len_counter.sv
// Saturating byte counter: clear wins over increment, and the count sticks at all-ones.
module sat_len_counter #(
  parameter int LEN_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [LEN_W-1:0] count_o
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;

  // Next count: restart on clear, otherwise step up until the ceiling is reached.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {LEN_W{1'b1}})) begin
      count_d = count_q + LEN_W'(1);
    end
  end

  // Hold the count; an asynchronous reset drops any partial frame length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tlp_frame_detector.sv
// Byte-serial PCIe framing parser that classifies TLPs and drives the statistics counter.
module tlp_frame_detector
  import tlp_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [7:0]       sym_data,
  input  logic             sym_k,
  output logic             tlp_done,
  output logic             tlp_err,
  output logic             tlp_null,
  output logic [LEN_W-1:0] tlp_len,
  output logic             cnt_enable,
  output logic             cnt_up
);

  localparam logic [LEN_W-1:0] MinLenC = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLenC = LEN_W'(MAX_LEN);

  tlpState_e        state_q;
  logic             tlpDone_q;
  logic             tlpErr_q;
  logic             tlpNull_q;
  logic             cntEnable_q;
  logic             cntUp_q;
  logic [LEN_W-1:0] tlpLen_q;

  logic [LEN_W-1:0] curLen;
  logic             lenClear;
  logic             lenInc;
  logic             lenInRange;

  // Any STP starts a fresh frame count regardless of where it arrives; the
  // closing frame's length is captured into tlpLen_q in the same cycle.
  assign lenClear   = sym_valid & sym_k & (sym_data == K_STP);
  assign lenInc     = sym_valid & ~sym_k & (state_q == ST_TLP);
  assign lenInRange = (curLen >= MinLenC) && (curLen <= MaxLenC);

  sat_len_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .clk     (clk),
    .reset   (reset),
    .clear_i (lenClear),
    .inc_i   (lenInc),
    .count_o (curLen)
  );

  // Framing FSM with registered one-cycle closure pulses and held frame length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tlpDone_q   <= 1'b0;
      tlpErr_q    <= 1'b0;
      tlpNull_q   <= 1'b0;
      cntEnable_q <= 1'b0;
      cntUp_q     <= 1'b0;
      tlpLen_q    <= '0;
    end else begin
      tlpDone_q   <= 1'b0;
      tlpErr_q    <= 1'b0;
      tlpNull_q   <= 1'b0;
      cntEnable_q <= 1'b0;
      cntUp_q     <= 1'b0;
      if (sym_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (sym_k) begin
              if (sym_data == K_STP) begin
                state_q <= ST_TLP;
              end else if (sym_data == K_SDP) begin
                state_q <= ST_DLLP;
              end
            end
          end
          ST_TLP: begin
            if (sym_k) begin
              tlpLen_q <= curLen;
              case (sym_data)
                K_END: begin
                  state_q     <= ST_IDLE;
                  cntEnable_q <= 1'b1;
                  if (lenInRange) begin
                    tlpDone_q <= 1'b1;
                    cntUp_q   <= 1'b1;
                  end else begin
                    tlpErr_q  <= 1'b1;
                  end
                end
                K_EDB: begin
                  state_q   <= ST_IDLE;
                  tlpNull_q <= 1'b1;
                end
                K_STP: begin
                  tlpErr_q    <= 1'b1;
                  cntEnable_q <= 1'b1;
                end
                K_SDP: begin
                  state_q     <= ST_DLLP;
                  tlpErr_q    <= 1'b1;
                  cntEnable_q <= 1'b1;
                end
                default: begin
                  state_q     <= ST_IDLE;
                  tlpErr_q    <= 1'b1;
                  cntEnable_q <= 1'b1;
                end
              endcase
            end
          end
          ST_DLLP: begin
            if (sym_k) begin
              if ((sym_data == K_END) || (sym_data == K_EDB)) begin
                state_q <= ST_IDLE;
              end else if (sym_data == K_STP) begin
                state_q <= ST_TLP;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tlp_done   = tlpDone_q;
  assign tlp_err    = tlpErr_q;
  assign tlp_null   = tlpNull_q;
  assign tlp_len    = tlpLen_q;
  assign cnt_enable = cntEnable_q;
  assign cnt_up     = cntUp_q;

endmodule

// File: tb/tb_tlp_frame_detector.sv
// Randomised and directed bench for tlp_frame_detector against a frame-level reference model.
module tb_tlp_frame_detector;

  localparam int LEN_W   = 13;
  localparam int MIN_LEN = 18;
  localparam int MAX_LEN = 4122;
  localparam int LEN_SAT = (1 << LEN_W) - 1;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;

  logic             clk = 1'b0;
  logic             reset;
  logic             sym_valid;
  logic [7:0]       sym_data;
  logic             sym_k;
  logic             tlp_done;
  logic             tlp_err;
  logic             tlp_null;
  logic [LEN_W-1:0] tlp_len;
  logic             cnt_enable;
  logic             cnt_up;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = between packets, 1 = inside a TLP, 2 = inside a DLLP.
  int mMode    = 0;
  int mCount   = 0;
  int mLastLen = 0;
  bit eDone    = 1'b0;
  bit eErr     = 1'b0;
  bit eNull    = 1'b0;

  tlp_frame_detector #(
    .LEN_W   (LEN_W),
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_k      (sym_k),
    .tlp_done   (tlp_done),
    .tlp_err    (tlp_err),
    .tlp_null   (tlp_null),
    .tlp_len    (tlp_len),
    .cnt_enable (cnt_enable),
    .cnt_up     (cnt_up)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got done/err/null/en/up=%b len=%0d, expected %b len=%0d",
               tag, $time, observed[17:13], observed[12:0], expected[17:13], expected[12:0]);
    end
  endtask

  function automatic logic [31:0] observedVec();
    return {14'd0, tlp_done, tlp_err, tlp_null, cnt_enable, cnt_up, tlp_len};
  endfunction

  function automatic logic [31:0] expectedVec();
    return {14'd0, eDone, eErr, eNull, eDone | eErr, eDone, 13'(mLastLen)};
  endfunction

  task automatic modelReset();
    mMode = 0; mCount = 0; mLastLen = 0;
    eDone = 1'b0; eErr = 1'b0; eNull = 1'b0;
  endtask

  // Closing a TLP records its byte count and raises exactly one verdict.
  task automatic modelClose(input int verdict);
    mLastLen = mCount;
    eDone = (verdict == 0);
    eErr  = (verdict == 1);
    eNull = (verdict == 2);
  endtask

  task automatic modelStep(input bit v, input bit k, input logic [7:0] d);
    eDone = 1'b0; eErr = 1'b0; eNull = 1'b0;
    if (!v) return;
    if (mMode == 1) begin
      if (!k) begin
        if (mCount < LEN_SAT) mCount = mCount + 1;
      end else if (d == ENDK) begin
        modelClose((mCount >= MIN_LEN && mCount <= MAX_LEN) ? 0 : 1);
        mMode = 0;
      end else if (d == EDB) begin
        modelClose(2);
        mMode = 0;
      end else if (d == STP) begin
        modelClose(1);
        mCount = 0;
      end else if (d == SDP) begin
        modelClose(1);
        mMode = 2;
      end else begin
        modelClose(1);
        mMode = 0;
      end
    end else if (k && d == STP) begin
      mMode = 1;
      mCount = 0;
    end else if (mMode == 0 && k && d == SDP) begin
      mMode = 2;
    end else if (mMode == 2 && k && (d == ENDK || d == EDB)) begin
      mMode = 0;
    end
  endtask

  // One symbol per cycle: drive on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input bit v, input bit k, input logic [7:0] d, input string tag);
    @(negedge clk);
    sym_valid = v;
    sym_k     = k;
    sym_data  = d;
    @(posedge clk);
    modelStep(v, k, d);
    #1;
    checkOutput(tag, observedVec(), expectedVec());
  endtask

  task automatic sendK(input logic [7:0] code, input string tag);
    applyStimulus(1'b1, 1'b1, code, tag);
  endtask

  task automatic sendData(input int n, input int gapPct, input string tag);
    for (int i = 0; i < n; i++) begin
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), {tag, "_gap"});
      applyStimulus(1'b1, 1'b0, 8'($urandom), tag);
    end
  endtask

  task automatic sendFrame(input int n, input logic [7:0] closer, input string tag);
    sendK(STP, {tag, "_stp"});
    sendData(n, 0, {tag, "_data"});
    sendK(closer, {tag, "_close"});
  endtask

  initial begin
    logic [7:0] closer;
    int         len;
    reset     = 1'b1;
    sym_valid = 1'b0;
    sym_k     = 1'b0;
    sym_data  = 8'h00;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", observedVec(), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed frames");
    sendFrame(18, ENDK, "good18");
    sendFrame(10, ENDK, "runt10");
    sendFrame(20, EDB, "null20");
    sendK(STP, "restart_stp1");
    sendData(5, 0, "restart_d5");
    sendFrame(18, ENDK, "restart_second");
    sendK(STP, "gaps_stp");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, ENDK, "gaps_idle");
      applyStimulus(1'b1, 1'b0, 8'($urandom), "gaps_data");
    end
    sendK(ENDK, "gaps_end");
    sendK(SDP, "dllp_sdp");
    sendData(6, 0, "dllp_data");
    sendK(STP, "dllp_stp_inside");
    sendData(3, 0, "dllp_tlp");
    sendK(ENDK, "dllp_tlp_end");
    sendK(SDP, "dllp2_sdp");
    sendData(4, 0, "dllp2_data");
    sendK(ENDK, "dllp2_end");
    sendK(ENDK, "idle_end");
    sendK(EDB, "idle_edb");
    applyStimulus(1'b1, 1'b0, STP, "idle_data_fb");

    $display("[TB] boundaries");
    sendFrame(17, ENDK, "len17");
    sendFrame(0, ENDK, "len0");
    sendFrame(MAX_LEN, ENDK, "lenMax");
    sendFrame(MAX_LEN + 1, ENDK, "lenMaxPlus1");
    sendFrame(LEN_SAT + 9, ENDK, "lenSaturated");
    sendFrame(7, COM, "other_k");
    sendFrame(4, SDP, "tlp_to_sdp");
    sendK(ENDK, "tlp_to_sdp_end");
    sendFrame(18, ENDK, "b2b_first");
    sendFrame(19, ENDK, "b2b_second");

    $display("[TB] reset mid-TLP");
    sendK(STP, "rst_stp");
    sendData(9, 0, "rst_data");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async", observedVec(), expectedVec());
    sym_valid = 1'b1;
    sym_k     = 1'b1;
    sym_data  = ENDK;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("rst_hold", observedVec(), expectedVec());
    end
    @(negedge clk);
    reset = 1'b0;
    sendFrame(18, ENDK, "rst_after");

    $display("[TB] random frames");
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 99) < 15) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rnd_junk");
      end
      sendK(($urandom_range(0, 99) < 85) ? STP : SDP, "rnd_open");
      case ($urandom_range(0, 5))
        0: len = MIN_LEN - 1;
        1: len = MIN_LEN;
        2: len = MIN_LEN + 1;
        3: len = $urandom_range(0, 40);
        4: len = $urandom_range(MIN_LEN, 60);
        default: len = 0;
      endcase
      sendData(len, 25, "rnd_data");
      case ($urandom_range(0, 9))
        6: closer = EDB;
        7: closer = STP;
        8: closer = SDP;
        9: closer = COM;
        default: closer = ENDK;
      endcase
      sendK(closer, "rnd_close");
    end
    applyStimulus(1'b0, 1'b0, 8'h00, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlp_frame_detector.md
Name: tlp_frame_detector

Overview:
- Byte-serial PCIe framing parser; sits directly upstream of the TLP statistics up/down counter.
- Consumes one 8b symbol per cycle with a K-character flag.
- Tracks STP/SDP/END/EDB framing and measures TLP length between STP and END.
- Classifies each TLP as good, malformed or nullified, and emits the enable/up pulse pair that drives the counter (+1 per good TLP, -1 per malformed TLP).

Parameters:
- LEN_W, 13: width of the byte-length counter and of tlp_len.
- MIN_LEN, 18: minimum legal byte count between STP and END (seq 2 + hdr 12 + LCRC 4).
- MAX_LEN, 4122: maximum legal byte count between STP and END.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sym_valid  input  1  sym_data/sym_k are meaningful this cycle.
- sym_data  input  8  received symbol.
- sym_k  input  1  1 = sym_data is a K-character.
- tlp_done  output  1  one-cycle pulse: good TLP closed.
- tlp_err  output  1  one-cycle pulse: malformed TLP closed.
- tlp_null  output  1  one-cycle pulse: TLP nullified by EDB.
- tlp_len  output  LEN_W  byte count of the last closed TLP (done/err/null); saturating.
- cnt_enable  output  1  counter enable pulse.
- cnt_up  output  1  counter direction; meaningful only when cnt_enable=1.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal length 0.
- Reset asserted mid-TLP: discards the frame with no pulse; FSM re-enters IDLE.
- K-codes: STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE. Recognised only when sym_k=1.
- Gating: sym_valid=0 means the cycle is ignored; state, length and tlp_len hold, and pulses deassert.
- States: IDLE, TLP, DLLP.
- IDLE:
  - STP goes to TLP with len cleared to 0.
  - SDP goes to DLLP.
  - All other symbols stay in IDLE with no output.
- TLP, data byte (sym_k=0): len increments, saturating at 2^LEN_W-1.
- TLP, END: goes to IDLE.
  - If MIN_LEN <= len <= MAX_LEN: tlp_done=1, cnt_enable=1, cnt_up=1.
  - Otherwise: tlp_err=1, cnt_enable=1, cnt_up=0.
- TLP, EDB: tlp_null=1, cnt_enable=0; goes to IDLE.
- TLP, STP: premature restart. Old frame gets tlp_err with a down pulse; new frame starts with len=0 and state stays TLP.
- TLP, SDP: old frame gets tlp_err with a down pulse; goes to DLLP.
- TLP, any other K (including COM/SKP): tlp_err with a down pulse; goes to IDLE.
- DLLP:
  - END or EDB goes to IDLE with no output.
  - STP goes to TLP with len=0 and no error.
  - Data and other symbols are ignored.
- Latency: outputs are registered; a pulse appears exactly 1 cycle after the closing symbol is sampled.
- tlp_len: updated in the same cycle as the pulse and holds until the next closure. It carries the closing frame's len, not the new frame's.
- Mutual exclusion: tlp_done, tlp_err and tlp_null are one-hot or zero in every cycle. cnt_enable = tlp_done | tlp_err; cnt_up = tlp_done.
- Back-to-back: END followed immediately by STP is legal and gives a 1-cycle gap between the pulse and the new frame's counting.
- Saturated len: always exceeds MAX_LEN, so END on a saturated frame yields tlp_err.

Decomposition:
- Shared package tlp_pkg holds:
  - K-code constants K_STP, K_SDP, K_END, K_EDB.
  - State enum for IDLE/TLP/DLLP.
  - Defaults for MIN_LEN/MAX_LEN.
- One natural sub-module, sat_len_counter: a LEN_W saturating counter with clear and increment.
- The FSM and output registers stay in the top module.

Test Plan:
- Good frame: STP, 18 data bytes, END -> tlp_done=1, cnt_enable=1, cnt_up=1, tlp_len=18, all one cycle after END.
- Runt frame: STP, 10 data bytes, END -> tlp_err=1, cnt_enable=1, cnt_up=0, tlp_len=10.
- Nullified frame: STP, 20 data bytes, EDB -> tlp_null=1, cnt_enable=0, tlp_len=20.
- Premature restart: STP, 5 bytes, STP, 18 bytes, END -> tlp_err (tlp_len=5), then tlp_done (tlp_len=18); counter pulse sequence down then up.
- Idle gaps: STP, 18 bytes with sym_valid=0 inserted between every byte, END -> tlp_done, tlp_len=18.
  - DLLP skipping: SDP, 6 bytes, END -> no pulses.
- Reset mid-TLP: reset asserted after STP + 9 bytes, released, then STP + 18 + END -> no pulse during reset; all outputs 0 asynchronously; a single tlp_done with tlp_len=18 afterwards.
